// File: rtl/ddram_responder.sv
// DDRAM initiator responder: on-chip 64-bit memory with burst writes,
// fixed-latency burst reads and a sticky protocol-error flag.
module ddram_responder #(
  parameter int AW         = 10,
  parameter int RD_LATENCY = 4
) (
  input  logic        DDRAM_CLK,
  input  logic        reset_n,
  output logic        DDRAM_BUSY,
  input  logic [7:0]  DDRAM_BURSTCNT,
  input  logic [28:0] DDRAM_ADDR,
  input  logic        DDRAM_RD,
  input  logic        DDRAM_WE,
  input  logic [63:0] DDRAM_DIN,
  input  logic [7:0]  DDRAM_BE,
  output logic [63:0] DDRAM_DOUT,
  output logic        DDRAM_DOUT_READY,
  input  logic        stall,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WBURST,
    S_RWAIT,
    S_RBURST
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_cnt;
  logic [3:0]    r_lat;
  logic [63:0]   r_dout;
  logic          r_rdy;
  logic          r_err;
  logic [63:0]   r_mem [2**AW];

  logic          w_idle;
  logic          w_wb;
  logic          w_acc_wr;
  logic          w_acc_rd;
  logic          w_cnt0;
  logic [7:0]    w_cnt;
  logic [AW-1:0] w_waddr;
  logic          w_unused;

  assign w_idle = (r_state == S_IDLE);
  assign w_wb   = (r_state == S_WBURST);

  assign DDRAM_BUSY = (w_idle | w_wb) ? stall : 1'b1;

  // reset_n gating keeps a write from landing while the core is held in reset
  assign w_acc_wr = reset_n & DDRAM_WE & ~DDRAM_BUSY
                  & (w_idle | w_wb);
  assign w_acc_rd = w_idle & DDRAM_RD & ~DDRAM_WE
                  & ~DDRAM_BUSY;

  assign w_cnt0  = (DDRAM_BURSTCNT == 8'd0);
  assign w_cnt   = w_cnt0 ? 8'd1 : DDRAM_BURSTCNT;
  assign w_waddr = w_idle ? DDRAM_ADDR[AW-1:0] : r_addr;

  assign w_unused = &{1'b0, DDRAM_ADDR[28:AW]};

  assign DDRAM_DOUT       = r_dout;
  assign DDRAM_DOUT_READY = r_rdy;
  assign proto_err        = r_err;

  always_ff @(posedge DDRAM_CLK) begin
    if (w_acc_wr) begin
      for (int b = 0; b < 8; b++) begin
        if (DDRAM_BE[b])
          r_mem[w_waddr][8*b +: 8] <= DDRAM_DIN[8*b +: 8];
      end
    end
  end

  always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_lat   <= '0;
      r_dout  <= '0;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_rdy <= 1'b0;
          if (w_acc_wr) begin
            if (w_cnt0 | DDRAM_RD)
              r_err <= 1'b1;
            if (w_cnt > 8'd1) begin
              r_addr  <= w_waddr + 1'b1;
              r_cnt   <= w_cnt - 1'b1;
              r_state <= S_WBURST;
            end
          end else if (w_acc_rd) begin
            if (w_cnt0)
              r_err <= 1'b1;
            r_addr  <= DDRAM_ADDR[AW-1:0];
            r_cnt   <= w_cnt;
            r_lat   <= 4'(RD_LATENCY - 1);
            r_state <= S_RWAIT;
          end
        end
        S_WBURST: begin
          if (DDRAM_RD & ~DDRAM_BUSY)
            r_err <= 1'b1;
          if (w_acc_wr) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == 8'd1)
              r_state <= S_IDLE;
          end
        end
        S_RWAIT: begin
          if (r_lat == 4'd0) begin
            r_dout  <= r_mem[r_addr];
            r_rdy   <= 1'b1;
            r_addr  <= r_addr + 1'b1;
            r_cnt   <= r_cnt - 1'b1;
            r_state <= S_RBURST;
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        S_RBURST: begin
          // r_cnt counts beats still to issue after the one now on DOUT
          if (r_cnt == 8'd0) begin
            r_rdy   <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_dout <= r_mem[r_addr];
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddram_responder.sv
// Directed self-checking bench for ddram_responder (AW=10, RD_LATENCY=4).
module tb_ddram_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [7:0]  bc = '0;
  logic [28:0] addr = '0;
  logic        rd = 1'b0;
  logic        we = 1'b0;
  logic [63:0] din = '0;
  logic [7:0]  be = '0;
  logic [63:0] dout;
  logic        rdy;
  logic        stall = 1'b0;
  logic        perr;

  int errs = 0;
  int checks = 0;

  logic        rdy_at [32];
  logic        busy_at [32];
  logic [63:0] d_at [32];

  ddram_responder #(.AW(10), .RD_LATENCY(4)) dut (
    .DDRAM_CLK       (clk),
    .reset_n         (rst_n),
    .DDRAM_BUSY      (busy),
    .DDRAM_BURSTCNT  (bc),
    .DDRAM_ADDR      (addr),
    .DDRAM_RD        (rd),
    .DDRAM_WE        (we),
    .DDRAM_DIN       (din),
    .DDRAM_BE        (be),
    .DDRAM_DOUT      (dout),
    .DDRAM_DOUT_READY(rdy),
    .stall           (stall),
    .proto_err       (perr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic wr1(input logic [28:0] a,
                     input logic [63:0] d,
                     input logic [7:0] b);
    addr = a; din = d; be = b; bc = 8'd1; we = 1'b1;
    tick;
    we = 1'b0;
  endtask

  // k = cycles after the acceptance edge; beat expected first at k=4
  task automatic rd_collect(input logic [28:0] a, input logic [7:0] n);
    addr = a; bc = n; rd = 1'b1;
    tick;
    rd = 1'b0;
    rdy_at[0] = 1'b0; busy_at[0] = 1'b1; d_at[0] = '0;
    for (int k = 1; k < 32; k++) begin
      tick;
      rdy_at[k] = rdy; busy_at[k] = busy; d_at[k] = dout;
    end
  endtask

  task automatic test_reset;
    tick;
    checks++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL reset_busy got %b want 0", busy);
    end
    checks++;
    if (rdy !== 1'b0) begin
      errs++; $display("FAIL reset_rdy got %b want 0", rdy);
    end
    checks++;
    if (dout !== 64'd0) begin
      errs++; $display("FAIL reset_dout got %h want 0", dout);
    end
    checks++;
    if (perr !== 1'b0) begin
      errs++; $display("FAIL reset_perr got %b want 0", perr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    int cnt = 0;
    int first = -1;
    wr1(29'h10, 64'h1122334455667788, 8'hFF);
    rd_collect(29'h10, 8'd1);
    for (int k = 0; k < 32; k++)
      if (rdy_at[k] === 1'b1) begin
        cnt++;
        if (first < 0) first = k;
      end
    checks++;
    if (first != 4) begin
      errs++; $display("FAIL single_latency got %0d want 4", first);
    end
    checks++;
    if (cnt != 1) begin
      errs++; $display("FAIL single_beats got %0d want 1", cnt);
    end
    checks++;
    if (d_at[4] !== 64'h1122334455667788) begin
      errs++; $display("FAIL single_data got %h want 1122334455667788", d_at[4]);
    end
    checks++;
    if (busy_at[1] !== 1'b1 || busy_at[5] !== 1'b0) begin
      errs++; $display("FAIL single_busy got %b%b want 10", busy_at[1], busy_at[5]);
    end
  endtask

  task automatic test_byte_enable;
    wr1(29'h10, 64'hAA, 8'h01);
    rd_collect(29'h10, 8'd1);
    checks++;
    if (d_at[4] !== 64'h11223344556677AA) begin
      errs++; $display("FAIL be_data got %h want 11223344556677aa", d_at[4]);
    end
    checks++;
    if (rdy_at[10] !== 1'b0 || d_at[10] !== 64'h11223344556677AA) begin
      errs++; $display("FAIL dout_hold got %b/%h want 0/11223344556677aa", rdy_at[10], d_at[10]);
    end
  endtask

  task automatic test_wrap_burst;
    int cnt = 0;
    int bad = 0;
    addr = 29'h3FE; bc = 8'd4; be = 8'hFF; din = 64'd1; we = 1'b1;
    tick;
    we = 1'b0;
    if (busy !== 1'b0) bad++;
    tick;
    din = 64'd2; we = 1'b1;
    tick;
    we = 1'b0;
    tick;
    din = 64'd3; we = 1'b1;
    tick;
    din = 64'd4;
    tick;
    we = 1'b0;
    if (busy !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      errs++; $display("FAIL wburst_busy got %0d busy cycles want 0", bad);
    end
    rd_collect(29'h3FE, 8'd4);
    for (int k = 0; k < 32; k++)
      if (rdy_at[k] === 1'b1) cnt++;
    checks++;
    if (cnt != 4 || rdy_at[3] !== 1'b0 || rdy_at[4] !== 1'b1 ||
        rdy_at[7] !== 1'b1) begin
      errs++; $display("FAIL wrap_beats got %0d beats want 4 at k=4..7", cnt);
    end
    checks++;
    if ({d_at[4][7:0], d_at[5][7:0], d_at[6][7:0], d_at[7][7:0]} !== 32'h01020304) begin
      errs++; $display("FAIL wrap_data got %h %h %h %h want 1 2 3 4", d_at[4], d_at[5], d_at[6], d_at[7]);
    end
    checks++;
    if (busy_at[8] !== 1'b0) begin
      errs++; $display("FAIL wrap_busy_end got %b want 0", busy_at[8]);
    end
    rd_collect(29'h000, 8'd2);
    checks++;
    if (d_at[4] !== 64'd3 || d_at[5] !== 64'd4) begin
      errs++; $display("FAIL wrap_low got %h %h want 3 4", d_at[4], d_at[5]);
    end
    rd_collect(29'h7FF, 8'd1);
    checks++;
    if (d_at[4] !== 64'd2) begin
      errs++; $display("FAIL addr_upper got %h want 2", d_at[4]);
    end
  endtask

  task automatic test_stall;
    int bad = 0;
    stall = 1'b1; addr = 29'h10; bc = 8'd1; rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (busy !== 1'b1 || rdy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errs++; $display("FAIL stall_hold got %0d bad cycles want 0", bad);
    end
    stall = 1'b0;
    rd_collect(29'h10, 8'd1);
    checks++;
    if (rdy_at[3] !== 1'b0 || rdy_at[4] !== 1'b1 ||
        d_at[4] !== 64'h11223344556677AA) begin
      errs++; $display("FAIL stall_accept got %b/%h want 1/11223344556677aa", rdy_at[4], d_at[4]);
    end
    checks++;
    if (perr !== 1'b0) begin
      errs++; $display("FAIL stall_perr got %b want 0", perr);
    end
  endtask

  task automatic test_rd_we_conflict;
    int cnt = 0;
    addr = 29'h20; din = 64'hCAFE0000BEEF0001; be = 8'hFF; bc = 8'd1;
    rd = 1'b1; we = 1'b1;
    tick;
    rd = 1'b0; we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (rdy === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errs++; $display("FAIL conflict_beats got %0d want 0", cnt);
    end
    checks++;
    if (perr !== 1'b1) begin
      errs++; $display("FAIL conflict_perr got %b want 1", perr);
    end
    rd_collect(29'h20, 8'd1);
    checks++;
    if (d_at[4] !== 64'hCAFE0000BEEF0001 || perr !== 1'b1) begin
      errs++; $display("FAIL conflict_write got %h/%b want cafe0000beef0001/1", d_at[4], perr);
    end
  endtask

  task automatic test_abort_reset;
    int cnt = 0;
    do_reset;
    checks++;
    if (perr !== 1'b0) begin
      errs++; $display("FAIL abort_perr_clr got %b want 0", perr);
    end
    addr = 29'h40; bc = 8'd8; be = 8'hFF; we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 64'h100 + 64'(i);
      tick;
    end
    we = 1'b0;
    addr = 29'h40; bc = 8'd8; rd = 1'b1;
    tick;
    rd = 1'b0;
    for (int k = 1; k <= 5; k++) tick;
    checks++;
    if (rdy !== 1'b1 || dout !== 64'h101) begin
      errs++; $display("FAIL abort_beat2 got %b/%h want 1/101", rdy, dout);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rdy !== 1'b0 || busy !== 1'b0 || dout !== 64'd0) begin
      errs++; $display("FAIL abort_async got %b/%b/%h want 0/0/0", rdy, busy, dout);
    end
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (rdy === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errs++; $display("FAIL abort_no_beats got %0d want 0", cnt);
    end
    rd_collect(29'h43, 8'd1);
    checks++;
    if (d_at[4] !== 64'h103) begin
      errs++; $display("FAIL abort_mem got %h want 103", d_at[4]);
    end
  endtask

  task automatic test_rd_in_wburst;
    addr = 29'h60; bc = 8'd2; be = 8'hFF; din = 64'h61; we = 1'b1;
    tick;
    we = 1'b0;
    checks++;
    if (perr !== 1'b0) begin
      errs++; $display("FAIL wb_perr_pre got %b want 0", perr);
    end
    rd = 1'b1;
    tick;
    rd = 1'b0; din = 64'h62; we = 1'b1;
    tick;
    we = 1'b0;
    checks++;
    if (perr !== 1'b1) begin
      errs++; $display("FAIL wb_rd_perr got %b want 1", perr);
    end
    rd_collect(29'h61, 8'd1);
    checks++;
    if (d_at[4] !== 64'h62) begin
      errs++; $display("FAIL wb_after_rd got %h want 62", d_at[4]);
    end
  endtask

  task automatic test_zero_count;
    int cnt = 0;
    do_reset;
    addr = 29'h50; bc = 8'd0; be = 8'hFF; din = 64'h55; we = 1'b1;
    tick;
    we = 1'b0;
    checks++;
    if (perr !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL zero_wr got %b/%b want perr 1 busy 0", perr, busy);
    end
    wr1(29'h51, 64'h66, 8'hFF);
    rd_collect(29'h50, 8'd0);
    for (int k = 0; k < 32; k++)
      if (rdy_at[k] === 1'b1) cnt++;
    checks++;
    if (cnt != 1 || d_at[4] !== 64'h55) begin
      errs++; $display("FAIL zero_rd got %0d/%h want 1/55", cnt, d_at[4]);
    end
    rd_collect(29'h51, 8'd1);
    checks++;
    if (d_at[4] !== 64'h66) begin
      errs++; $display("FAIL zero_next got %h want 66", d_at[4]);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_byte_enable;
    test_wrap_burst;
    test_stall;
    test_rd_we_conflict;
    test_abort_reset;
    test_rd_in_wburst;
    test_zero_count;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
